// File: rtl/berg_bus_pkg.sv
// Shared types and default constants for the Berg ribbon bus stages.
package berg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int BERG_DATA_W      = 8;
    localparam int BERG_SYNC_STAGES = 2;

endpackage

// File: rtl/berg_sync_fifo.sv
// Synchronous circular-buffer FIFO with push/pop, occupancy and a registered head word.
module berg_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]  level_reg, level_next;
    logic [DATA_W-1:0] head_reg, head_next;
    logic              valid_reg;
    logic              push_ok, pop_ok;

    assign pop_ok  = pop && (level_reg != '0);
    assign push_ok = push && ((level_reg != LVL_W'(DEPTH)) || pop_ok);

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        level_next  = level_reg;
        head_next   = head_reg;
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
        // The new head may be the word being written this very cycle.
        if (level_next != '0) begin
            if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            head_reg   <= head_next;
            valid_reg  <= (level_next != '0);
        end
    end

    assign out_data  = head_reg;
    assign out_valid = valid_reg;
    assign level     = level_reg;

endmodule

// File: rtl/berg_bus_rx.sv
// Receive stage behind the Berg ribbon: synchronises strobe/data, runs the
// four-phase strobe/ack handshake and buffers words for a valid/ready consumer.
module berg_bus_rx
    import berg_bus_pkg::*;
#(
    parameter int DATA_W      = BERG_DATA_W,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = BERG_SYNC_STAGES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        cbl_data,
    input  logic                     cbl_strobe,
    output logic                     cbl_ack,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     proto_err,
    input  logic                     clr_err
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              strobe_feed   [SYNC_STAGES];
    logic [DATA_W-1:0] data_feed     [SYNC_STAGES];
    logic              strobe_sync_reg [SYNC_STAGES];
    logic [DATA_W-1:0] data_sync_reg   [SYNC_STAGES];

    logic [SYNC_STAGES-1:0] primed_reg;
    logic                   armed_reg;
    logic                   strobe_d_reg;
    logic                   strobe_s;
    logic [DATA_W-1:0]      data_s;
    logic                   strobe_rise;

    state_t state_reg, state_next;
    logic   ack_reg;
    logic   err_reg, err_set;
    logic   push, space;

    logic [LVL_W-1:0] fifo_level;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync_feed
        if (gi == 0) begin : g_head
            assign strobe_feed[gi] = cbl_strobe;
            assign data_feed[gi]   = cbl_data;
        end else begin : g_chain
            assign strobe_feed[gi] = strobe_sync_reg[gi-1];
            assign data_feed[gi]   = data_sync_reg[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                strobe_sync_reg[i] <= 1'b0;
                data_sync_reg[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                strobe_sync_reg[i] <= strobe_feed[i];
                data_sync_reg[i]   <= data_feed[i];
            end
        end
    end

    assign strobe_s = strobe_sync_reg[SYNC_STAGES-1];
    assign data_s   = data_sync_reg[SYNC_STAGES-1];

    // After reset the synchroniser holds zeros rather than the real line, so a
    // strobe left high across reset must be seen low once before a rise counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            primed_reg   <= '0;
            armed_reg    <= 1'b0;
            strobe_d_reg <= 1'b0;
        end else begin
            primed_reg   <= {primed_reg[SYNC_STAGES-2:0], 1'b1};
            armed_reg    <= armed_reg | (primed_reg[SYNC_STAGES-1] & ~strobe_s);
            strobe_d_reg <= strobe_s;
        end
    end

    assign strobe_rise = armed_reg & strobe_s & ~strobe_d_reg;

    // Full FIFO still has room when the consumer pops on the same edge.
    assign space = (fifo_level != LVL_W'(DEPTH)) || out_ready;

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (strobe_rise) begin
                    if (space) begin
                        push       = 1'b1;
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!strobe_s) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else if (space) begin
                    push       = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!strobe_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= (state_next == ACK);
            if (err_set) begin
                err_reg <= 1'b1;
            end else if (clr_err) begin
                err_reg <= 1'b0;
            end
        end
    end

    berg_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (data_s),
        .pop       (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .level     (fifo_level)
    );

    assign cbl_ack   = ack_reg;
    assign level     = fifo_level;
    assign proto_err = err_reg;

endmodule
